// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// MEM-stage data-access unit sitting between the EX/MEM pipeline register and
// data-memory port B. Converts RV32 byte/halfword/word loads and stores into
// word-wide port-B accesses. Loads complete combinationally in the same cycle.
// Word stores and all MMIO stores are single-cycle writes. Sub-word stores to
// RAM run as a two-cycle read-modify-write, stalling the pipeline for the
// read cycle.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned accesses are suppressed and flagged on o_misalign
//   undefined : o_misalign is tied to 0 and the address is force-aligned
//
// Ports:
//   i_clk, i_reset    core clock, synchronous active-high reset
//   i_req_*           memory operation held in the MEM stage
//   o_stall           freeze PC, IF/ID, ID/EX and EX/MEM this cycle
//   o_resp_valid      access completes this cycle
//   o_resp_rdata      sign/zero-extended load data
//   o_misalign        misaligned-access exception
//   o_mem_addr/o_mem_wdata/o_mem_we/i_mem_rdata   data-memory port B
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter logic [15:0] MMIO_HI = 16'hffff
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    input  logic              i_req_write,
    input  logic [2:0]        i_req_funct3,
    input  logic [DATA_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_stall,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic              o_misalign,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic {
        StIdle,
        StRmwWr
    } state_e;

    state_e r_state;
    state_e w_state_d;

    // Captured sub-word store context for the write half of the RMW
    logic [DATA_W-1:0] r_waddr;
    logic [1:0]        r_lane;
    logic              r_half;
    logic [15:0]       r_wdata;
    logic [DATA_W-1:0] r_old_word;

    logic              w_is_byte;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_unsigned;
    logic              w_misalign;
    logic [DATA_W-1:0] w_addr_eff;
    logic [DATA_W-1:0] w_waddr;
    logic              w_mmio;
    logic              w_capture;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

    // funct3[1:0] == 2'b11 (and so 011/111) falls into the word class, as does 110
    assign w_is_byte  = (i_req_funct3[1:0] == 2'b00);
    assign w_is_half  = (i_req_funct3[1:0] == 2'b01);
    assign w_is_word  = !w_is_byte && !w_is_half;
    assign w_unsigned = i_req_funct3[2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = (w_is_half && i_req_addr[0]) || (w_is_word && (i_req_addr[1:0] != 2'b00));
    assign w_addr_eff = i_req_addr;
`else
    assign w_misalign = 1'b0;
    always_comb begin
        w_addr_eff = i_req_addr;
        if (w_is_half) begin
            w_addr_eff[0] = 1'b0;
        end else if (w_is_word) begin
            w_addr_eff[1:0] = 2'b00;
        end
    end
`endif

    assign w_waddr = {w_addr_eff[DATA_W-1:2], 2'b00};
    assign w_mmio  = (w_addr_eff[DATA_W-1 -: 16] == MMIO_HI);

    // Load lane select and extension
    always_comb begin
        w_byte = 8'h00;
        case (w_addr_eff[1:0])
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = w_addr_eff[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        if (w_is_byte) begin
            w_load = {{(DATA_W-8){!w_unsigned && w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            w_load = {{(DATA_W-16){!w_unsigned && w_half[15]}}, w_half};
        end else begin
            w_load = i_mem_rdata;
        end
    end

    // Merge captured store data into the previously read word
    always_comb begin
        w_merged = r_old_word;
        if (r_half) begin
            if (r_lane[1]) begin
                w_merged[31:16] = r_wdata;
            end else begin
                w_merged[15:0] = r_wdata;
            end
        end else begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end
    end

    // Next-state and outputs; reset forces every output low in the same cycle
    always_comb begin
        w_state_d    = r_state;
        w_capture    = 1'b0;
        o_stall      = 1'b0;
        o_resp_valid = 1'b0;
        o_resp_rdata = '0;
        o_misalign   = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_we     = 1'b0;
        if (!i_reset) begin
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        if (w_misalign) begin
                            o_misalign = 1'b1;
                        end else if (!i_req_write) begin
                            o_mem_addr   = w_waddr;
                            o_resp_valid = 1'b1;
                            o_resp_rdata = w_load;
                        end else if (w_is_word || w_mmio) begin
                            // MMIO sub-word stores write the whole wdata, no RMW
                            o_mem_addr   = w_waddr;
                            o_mem_wdata  = i_req_wdata;
                            o_mem_we     = 1'b1;
                            o_resp_valid = 1'b1;
                        end else begin
                            o_mem_addr = w_waddr;
                            o_stall    = 1'b1;
                            w_capture  = 1'b1;
                            w_state_d  = StRmwWr;
                        end
                    end
                end
                StRmwWr: begin
                    o_mem_addr   = r_waddr;
                    o_mem_wdata  = w_merged;
                    o_mem_we     = 1'b1;
                    o_resp_valid = 1'b1;
                    w_state_d    = StIdle;
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_waddr    <= '0;
            r_lane     <= 2'b00;
            r_half     <= 1'b0;
            r_wdata    <= 16'h0000;
            r_old_word <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_capture) begin
                r_waddr    <= w_waddr;
                r_lane     <= w_addr_eff[1:0];
                r_half     <= w_is_half;
                r_wdata    <= i_req_wdata[15:0];
                r_old_word <= i_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    int checks;
    int errors;

    load_store_unit dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .i_req_write  (req_write),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_stall      (stall),
        .o_resp_valid (resp_valid),
        .o_resp_rdata (resp_rdata),
        .o_misalign   (misalign),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_we     (mem_we),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port-B memory model: written on the falling edge, read combinationally
    logic [31:0] mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;

    always @(negedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid  = v;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        bd_we   = 1'b1;
        bd_idx  = a[9:2];
        bd_data = d;
        @(negedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        #2;
        checks++; if (mem_we !== 1'b0) begin errors++;
            $display("FAIL rst_active_we: got %h exp 0", mem_we); end
        checks++; if (resp_valid !== 1'b0) begin errors++;
            $display("FAIL rst_active_rv: got %h exp 0", resp_valid); end
        next_cycle();
        set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        next_cycle();
        reset = 1'b0;
        #2;
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL rst_stall: got %h exp 0", stall); end
        checks++; if (misalign !== 1'b0) begin errors++;
            $display("FAIL rst_misalign: got %h exp 0", misalign); end
        checks++; if (mem_addr !== 32'h0) begin errors++;
            $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++;
            $display("FAIL rst_mem_wdata: got %h exp 0", mem_wdata); end
        checks++; if (resp_rdata !== 32'h0) begin errors++;
            $display("FAIL rst_rdata: got %h exp 0", resp_rdata); end
        next_cycle();
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ad  [5] = '{32'h101, 32'h101, 32'h102, 32'h102, 32'h100};
        logic [31:0] exp [5] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899,
                                 32'h0000_8899, 32'h8899_AABB};
        preload(32'h100, 32'h8899_AABB);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 1'b0, f3[i], ad[i], 32'h0);
            #2;
            checks++; if (resp_rdata !== exp[i]) begin errors++;
                $display("FAIL load%0d_rdata: got %h exp %h", i, resp_rdata, exp[i]); end
            checks++; if (resp_valid !== 1'b1 || stall !== 1'b0 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL load%0d_ctl: got rv=%b st=%b we=%b exp 1 0 0",
                         i, resp_valid, stall, mem_we); end
            checks++; if (mem_addr !== 32'h100) begin errors++;
                $display("FAIL load%0d_addr: got %h exp 00000100", i, mem_addr); end
            next_cycle();
        end
        set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        next_cycle();
    endtask

    task automatic test_sb_rmw();
        set_req(1'b1, 1'b1, 3'b000, 32'h102, 32'hDEAD_BE11);
        #2;
        checks++; if (stall !== 1'b1 || mem_we !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL sb_c0: got st=%b we=%b rv=%b exp 1 0 0", stall, mem_we, resp_valid);
        end
        next_cycle();
        #2;
        checks++; if (mem_we !== 1'b1 || resp_valid !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_c1: got we=%b rv=%b st=%b exp 1 1 0", mem_we, resp_valid, stall);
        end
        checks++; if (mem_wdata !== 32'h8811_AABB) begin errors++;
            $display("FAIL sb_c1_wdata: got %h exp 8811aabb", mem_wdata); end
        checks++; if (mem_addr !== 32'h100) begin errors++;
            $display("FAIL sb_c1_addr: got %h exp 00000100", mem_addr); end
        next_cycle();
        set_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        #2;
        checks++; if (resp_rdata !== 32'h8811_AABB) begin errors++;
            $display("FAIL sb_readback: got %h exp 8811aabb", resp_rdata); end
        next_cycle();
        set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ad [2] = '{32'h100, 32'h102};
        logic [31:0] wd [2] = '{32'hFFFF_1234, 32'hAAAA_5678};
        logic        st_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 4; c++) begin
            set_req(1'b1, 1'b1, 3'b001, ad[c/2], wd[c/2]);
            #2;
            checks++; if (stall !== st_exp[c]) begin errors++;
                $display("FAIL b2b_stall%0d: got %b exp %b", c, stall, st_exp[c]); end
            next_cycle();
        end
        set_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        #2;
        checks++; if (resp_rdata !== 32'h5678_1234) begin errors++;
            $display("FAIL b2b_final: got %h exp 56781234", resp_rdata); end
        next_cycle();
    endtask

    task automatic test_mmio();
        set_req(1'b1, 1'b1, 3'b010, 32'hFFFF_FC60, 32'h0000_0005);
        #2;
        checks++; if (mem_we !== 1'b1 || stall !== 1'b0 || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL mmio_sw: got we=%b st=%b rv=%b exp 1 0 1", mem_we, stall, resp_valid);
        end
        checks++; if (mem_addr !== 32'hFFFF_FC60 || mem_wdata !== 32'h5) begin errors++;
            $display("FAIL mmio_sw_data: got %h/%h exp fffffc60/00000005", mem_addr, mem_wdata);
        end
        next_cycle();
        set_req(1'b1, 1'b1, 3'b000, 32'hFFFF_FC61, 32'hCAFE_00A5);
        #2;
        checks++; if (mem_we !== 1'b1 || stall !== 1'b0) begin errors++;
            $display("FAIL mmio_sb: got we=%b st=%b exp 1 0", mem_we, stall); end
        checks++; if (mem_addr !== 32'hFFFF_FC60 || mem_wdata !== 32'hCAFE_00A5) begin errors++;
            $display("FAIL mmio_sb_data: got %h/%h exp fffffc60/cafe00a5", mem_addr, mem_wdata);
        end
        next_cycle();
        set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #2;
        checks++; if (mem_we !== 1'b0 || resp_valid !== 1'b0) begin errors++;
            $display("FAIL mmio_no_rmw: got we=%b rv=%b exp 0 0", mem_we, resp_valid); end
        next_cycle();
    endtask

    task automatic test_misalign();
        set_req(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
        #2;
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (misalign !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL mis_lw: got m=%b rv=%b we=%b exp 1 0 0", misalign, resp_valid, mem_we);
        end
`else
        checks++; if (misalign !== 1'b0 || resp_rdata !== 32'h5678_1234) begin errors++;
            $display("FAIL mis_lw: got m=%b d=%h exp 0 56781234", misalign, resp_rdata); end
`endif
        next_cycle();
        set_req(1'b1, 1'b0, 3'b001, 32'h103, 32'h0);
        #2;
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (misalign !== 1'b1 || resp_valid !== 1'b0) begin errors++;
            $display("FAIL mis_lh: got m=%b rv=%b exp 1 0", misalign, resp_valid); end
`else
        checks++; if (misalign !== 1'b0 || resp_rdata !== 32'h0000_5678) begin errors++;
            $display("FAIL mis_lh: got m=%b d=%h exp 0 00005678", misalign, resp_rdata); end
`endif
        next_cycle();
    endtask

    task automatic test_illegal_funct3();
        logic [2:0] f3 [3] = '{3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 1'b0, f3[i], 32'h100, 32'h0);
            #2;
            checks++; if (resp_rdata !== 32'h5678_1234) begin errors++;
                $display("FAIL illegal%0d: got %h exp 56781234", i, resp_rdata); end
            next_cycle();
        end
    endtask

    task automatic test_reset_in_rmw();
        set_req(1'b1, 1'b1, 3'b000, 32'h100, 32'h0000_0077);
        #2;
        checks++; if (stall !== 1'b1) begin errors++;
            $display("FAIL rrmw_c0_stall: got %b exp 1", stall); end
        next_cycle();
        reset = 1'b1;
        #2;
        checks++; if (mem_we !== 1'b0 || resp_valid !== 1'b0) begin errors++;
            $display("FAIL rrmw_c1: got we=%b rv=%b exp 0 0", mem_we, resp_valid); end
        next_cycle();
        reset = 1'b0;
        set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #2;
        checks++; if (stall !== 1'b0 || mem_we !== 1'b0 || resp_valid !== 1'b0 ||
                      mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++;
            $display("FAIL rrmw_idle: got st=%b we=%b rv=%b a=%h d=%h exp all 0",
                     stall, mem_we, resp_valid, mem_addr, mem_wdata); end
        next_cycle();
        set_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        #2;
        checks++; if (resp_rdata !== 32'h5678_1234) begin errors++;
            $display("FAIL rrmw_unchanged: got %h exp 56781234", resp_rdata); end
        next_cycle();
        set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bd_we  = 1'b0;
        bd_idx = 8'h00;
        bd_data = 32'h0;
        reset  = 1'b1;
        set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        next_cycle();
        test_reset();
        test_loads();
        test_sb_rmw();
        test_back_to_back();
        test_mmio();
        test_misalign();
        test_illegal_funct3();
        test_reset_in_rmw();
        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
